muldiv_scheduler: RTL and testbench
===================================

Name: muldiv_scheduler

Overview:
Multi-cycle HI/LO unit for the EX stage of the 5-stage MIPS pipeline. It accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO request and sequences an iterative divider and a fixed-latency multiplier. It owns the HI/LO registers. It drives the stall/done pair consumed by the hazard unit, which freezes F/D/E and bubbles M while the operation runs, and it aborts cleanly on exception flush.

Parameters:
MUL_CYCLES, 3, cycles spent in MUL state (1..7); models pipelined DSP multiplier latency
DIV_ITERS, 32, restoring-division iterations (fixed to data width; not user-tunable beyond 32)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  EX-stage request valid, sampled only in IDLE
op  in  4  operation code (muldiv_pkg encoding)
src_a  in  32  rs operand (dividend / multiplicand / MTHI-MTLO data)
src_b  in  32  rt operand (divisor / multiplier)
flush  in  1  exception flush; aborts any operation
stall  out  1  operation in progress; hazard unit stalls pipeline
done  out  1  one-cycle pulse, HI/LO hold new result
busy  out  1  state != IDLE
hi  out  32  HI register
lo  out  32  LO register

Behaviour:
- Reset: state=IDLE, hi=lo=0, stall=0, done=0, busy=0, counter=0.
- States: IDLE, MUL, DIV, (ACC), DONE.
- IDLE + start + mul op (MULT/MULTU): latch operands → MUL; counter=MUL_CYCLES-1.
- IDLE + start + div op, src_b!=0: latch magnitudes and signs → DIV; counter=DIV_ITERS-1.
- IDLE + start + div op, src_b==0: → DONE directly. LO=0xFFFFFFFF, HI=src_a.
- IDLE + start + MTHI/MTLO: write hi/lo at next edge. No stall, no done, stay IDLE.
- MUL: count down; at 0 → DONE, writing {hi,lo} = 64-bit product. Signed for MULT (sign-extend to 33b), unsigned for MULTU.
- DIV: one restoring step per cycle on unsigned magnitudes; at counter 0 → DONE.
- DIV result fix-up on DONE entry: quotient negated if operand signs differ (DIV only); remainder takes dividend sign. LO=quotient, HI=remainder.
- DONE: done=1 for exactly one cycle, stall=0; → IDLE unconditionally.
- stall (combinational) = state∈{MUL,DIV,ACC} OR (state==IDLE & start & op∈{MULT,MULTU,DIV,DIVU,MADD*,MSUB*} & !flush). It is therefore high in the request cycle itself.
- Latency, start cycle = 0:
  - MUL: done in cycle MUL_CYCLES+1.
  - DIV: done in cycle DIV_ITERS+1 = 33.
  - Divide-by-zero: done in cycle 1.
- start while busy: ignored (pipeline is stalled; the EX request is held stable).
- flush in any state: next state IDLE; hi/lo NOT updated; no done; stall drops same cycle (combinationally gated by flush).
- flush and start same cycle: flush wins, no operation.
- flush arriving in DONE: hi/lo already committed, done still pulses (the result belongs to an instruction older than the faulting one).
- MTHI/MTLO with flush the same cycle: write suppressed.
- Undefined op codes with start: ignored.

Optional Feature:
MULDIV_ACC_EN.
- Defined: MADD/MADDU/MSUB/MSUBU are supported. They follow the MUL path, then spend one ACC cycle computing {hi,lo} ± product (64-bit wrap) → DONE. Done arrives in cycle MUL_CYCLES+2.
- Undefined: these codes are treated as undefined ops (ignored, no stall). The ACC state and its adder are absent.

Decomposition:
- muldiv_pkg: op codes (NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8, MSUB=9, MSUBU=10), state encoding, and the is_mul/is_div/is_acc classification functions.
- Sub-module muldiv_div_core: 32-bit unsigned restoring divider, one iteration per enable. It holds the partial remainder and quotient and exposes quotient/remainder. The scheduler owns the sign handling and the counter.

Test Plan:
- MULT a=0xFFFFFFFF b=0x00000002 → stall cycles 0..3, done in cycle 4, hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7) b=2 → done in cycle 33, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 → lo=14, hi=2.
- DIVU a=0x1234 b=0 → done in cycle 1, lo=0xFFFFFFFF, hi=0x1234; stall high in cycle 0 only.
- Preload hi=0xAAAA via MTHI, start DIV, assert flush in cycle 10 → stall low in cycle 10, busy low in cycle 11, no done, hi still 0xAAAA. Then start MULT 3*5 → lo=15.
- start+flush same cycle with op=MULT → stall=0, state stays IDLE. rst asserted mid-DIV → all outputs zero next cycle.
- (MULDIV_ACC_EN) hi=0, lo=0xFFFFFFFF, MADDU 1*1 → done in cycle 5, hi=1, lo=0. MSUB 1*1 from zero → hi=lo=0xFFFFFFFF.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states and
// helpers that classify ops and form the 64-bit product.
package muldiv_pkg;

  typedef enum logic [3:0] {
    OpNone  = 4'd0,
    OpMult  = 4'd1,
    OpMultu = 4'd2,
    OpDiv   = 4'd3,
    OpDivu  = 4'd4,
    OpMthi  = 4'd5,
    OpMtlo  = 4'd6,
    OpMadd  = 4'd7,
    OpMaddu = 4'd8,
    OpMsub  = 4'd9,
    OpMsubu = 4'd10
  } op_e;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StMul  = 3'd1,
    StDiv  = 3'd2,
    StAcc  = 3'd3,
    StDone = 3'd4
  } state_e;

  function automatic logic is_mul(logic [3:0] op);
    return (op == OpMult) || (op == OpMultu);
  endfunction

  function automatic logic is_div(logic [3:0] op);
    return (op == OpDiv) || (op == OpDivu);
  endfunction

  function automatic logic is_acc(logic [3:0] op);
    return (op == OpMadd) || (op == OpMaddu) || (op == OpMsub) || (op == OpMsubu);
  endfunction

  function automatic logic is_msub(logic [3:0] op);
    return (op == OpMsub) || (op == OpMsubu);
  endfunction

  function automatic logic is_signed_mul(logic [3:0] op);
    return (op == OpMult) || (op == OpMadd) || (op == OpMsub);
  endfunction

  // Sign- or zero-extend to 64 bits; the low 64 bits of the product are exact either way.
  function automatic logic [63:0] mul64(logic [31:0] a, logic [31:0] b, logic sgn);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = {{32{sgn & a[31]}}, a};
    eb = {{32{sgn & b[31]}}, b};
    return ea * eb;
  endfunction

endpackage

// File: rtl/muldiv_scheduler_if.sv
// Request/result bundle between the EX stage (master) and the HI/LO unit (slave).
interface muldiv_scheduler_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        stall;
  logic        done;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, src_a, src_b, flush,
    input  stall, done, busy, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, flush,
    output stall, done, busy, hi, lo
  );
endinterface

// File: rtl/muldiv_div_core.sv
// 32-bit unsigned restoring divider, one iteration per enabled cycle. Outputs show the
// quotient/remainder including the step taken this cycle when en_i is high.
module muldiv_div_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        en_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o
);

  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;
  logic [32:0] rem_shift;
  logic [32:0] diff;
  logic [31:0] quo_step;
  logic [31:0] rem_step;

  always_comb begin
    rem_shift = {rem_q, quo_q[31]};
    diff      = rem_shift - {1'b0, dvs_q};
    // Non-negative difference means the divisor fits: keep it and set the quotient bit.
    quo_step  = {quo_q[30:0], ~diff[32]};
    rem_step  = diff[32] ? rem_shift[31:0] : diff[31:0];
  end

  always_comb begin
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    if (load_i) begin
      quo_d = dividend_i;
      rem_d = '0;
      dvs_d = divisor_i;
    end else if (en_i) begin
      quo_d = quo_step;
      rem_d = rem_step;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
    end
  end

  assign quotient_o  = en_i ? quo_step : quo_q;
  assign remainder_o = en_i ? rem_step : rem_q;

endmodule

// File: rtl/muldiv_scheduler.sv
// HI/LO unit for the EX stage: sequences a fixed-latency multiplier and an iterative
// divider, owns HI/LO. Define MULDIV_ACC_EN to add MADD/MADDU/MSUB/MSUBU.
module muldiv_scheduler
  import muldiv_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 3,
  parameter int unsigned DIV_ITERS  = 32
) (
  input logic              clk,
  input logic              rst,
  muldiv_scheduler_if.slave bus
);

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [3:0]  op_q, op_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        mul_req;
  logic        div_req;
  logic        div_load;
  logic        div_en;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic [31:0] div_quo;
  logic [31:0] div_rem;
  logic [63:0] prod;

`ifdef MULDIV_ACC_EN
  assign mul_req = is_mul(bus.op) || is_acc(bus.op);
`else
  assign mul_req = is_mul(bus.op);
`endif
  assign div_req = is_div(bus.op);
  assign prod    = mul64(a_q, b_q, is_signed_mul(op_q));

  // Divider works on magnitudes; signs are restored when the result is committed.
  always_comb begin
    div_dividend = bus.src_a;
    div_divisor  = bus.src_b;
    if (bus.op == OpDiv) begin
      if (bus.src_a[31]) div_dividend = -bus.src_a;
      if (bus.src_b[31]) div_divisor  = -bus.src_b;
    end
  end

  muldiv_div_core u_div_core (
    .clk         (clk),
    .rst         (rst),
    .load_i      (div_load),
    .en_i        (div_en),
    .dividend_i  (div_dividend),
    .divisor_i   (div_divisor),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OpNone;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    div_load = 1'b0;
    div_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.flush) begin
          if (mul_req) begin
            a_d     = bus.src_a;
            b_d     = bus.src_b;
            op_d    = bus.op;
            cnt_d   = 6'(MUL_CYCLES - 1);
            state_d = StMul;
          end else if (div_req) begin
            if (bus.src_b == '0) begin
              lo_d    = '1;
              hi_d    = bus.src_a;
              state_d = StDone;
            end else begin
              div_load = 1'b1;
              q_neg_d  = (bus.op == OpDiv) && (bus.src_a[31] ^ bus.src_b[31]);
              r_neg_d  = (bus.op == OpDiv) && bus.src_a[31];
              cnt_d    = 6'(DIV_ITERS - 1);
              state_d  = StDiv;
            end
          end else if (bus.op == OpMthi) begin
            hi_d = bus.src_a;
          end else if (bus.op == OpMtlo) begin
            lo_d = bus.src_a;
          end
        end
      end
      StMul: begin
        if (bus.flush) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          {hi_d, lo_d} = prod;
          state_d      = StDone;
`ifdef MULDIV_ACC_EN
          if (is_acc(op_q)) begin
            hi_d    = hi_q;
            lo_d    = lo_q;
            state_d = StAcc;
          end
`endif
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      StDiv: begin
        if (bus.flush) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          div_en = 1'b1;
          if (cnt_q == '0) begin
            lo_d    = q_neg_q ? -div_quo : div_quo;
            hi_d    = r_neg_q ? -div_rem : div_rem;
            state_d = StDone;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
      end
`ifdef MULDIV_ACC_EN
      StAcc: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else begin
          {hi_d, lo_d} = is_msub(op_q) ? {hi_q, lo_q} - prod : {hi_q, lo_q} + prod;
          state_d      = StDone;
        end
      end
`endif
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Stall covers the request cycle itself so the hazard unit freezes EX immediately.
  always_comb begin
    bus.busy  = (state_q != StIdle);
    bus.done  = (state_q == StDone);
    bus.stall = 1'b0;
    if (!bus.flush) begin
      if (state_q == StMul || state_q == StDiv || state_q == StAcc) begin
        bus.stall = 1'b1;
      end else if (state_q == StIdle && bus.start && (mul_req || div_req)) begin
        bus.stall = 1'b1;
      end
    end
  end

  assign bus.hi = hi_q;
  assign bus.lo = lo_q;

endmodule

// File: tb/tb_muldiv_scheduler.sv
// Scoreboard bench for muldiv_scheduler: expected HI/LO pushed at issue, popped at done.
module tb_muldiv_scheduler;
  import muldiv_pkg::*;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  res_t exp_q[$];

  muldiv_scheduler_if bus ();

  muldiv_scheduler #(
    .MUL_CYCLES (3),
    .DIV_ITERS  (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request held until done; measures latency and stall cycles, never checks.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int done_cyc, output int stall_cnt, output logic done_after);
    done_cyc  = -1;
    stall_cnt = 0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.op    = o;
    bus.src_a = a;
    bus.src_b = b;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.stall) stall_cnt++;
      if (bus.done) begin
        done_cyc = c;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op    = OpNone;
    @(negedge clk);
    done_after = bus.done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", bus.stall); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_checks++; if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi got %h want 0", bus.hi); end
    n_checks++; if (bus.lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo got %h want 0", bus.lo); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic run_table(input string name, input logic [3:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                           input int ecyc, input int estall);
    int   dc;
    int   sc;
    logic da;
    res_t e;
    exp_q.push_back('{hi: ehi, lo: elo});
    issue(o, a, b, dc, sc, da);
    e = exp_q.pop_front();
    n_checks++; if (dc !== ecyc) begin n_fail++; $display("FAIL %s_latency got %0d want %0d", name, dc, ecyc); end
    n_checks++; if (sc !== estall) begin n_fail++; $display("FAIL %s_stall_cycles got %0d want %0d", name, sc, estall); end
    n_checks++; if (da !== 1'b0) begin n_fail++; $display("FAIL %s_done_width got %b want 0", name, da); end
    n_checks++; if (bus.hi !== e.hi) begin n_fail++; $display("FAIL %s_hi got %h want %h", name, bus.hi, e.hi); end
    n_checks++; if (bus.lo !== e.lo) begin n_fail++; $display("FAIL %s_lo got %h want %h", name, bus.lo, e.lo); end
  endtask

  task automatic test_mul();
    run_table("mult_neg", OpMult,  32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, 4, 4);
    run_table("multu",    OpMultu, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE, 4, 4);
    run_table("mult_mm",  OpMult,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 4, 4);
    run_table("multu_max", OpMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 4, 4);
    run_table("mult_min", OpMult,  32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 4, 4);
  endtask

  task automatic test_div();
    run_table("div_m7_2",  OpDiv,  32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 33);
    run_table("divu_100_7", OpDivu, 32'd100, 32'd7, 32'd2, 32'd14, 33, 33);
    run_table("div_7_m2",  OpDiv,  32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 33, 33);
    run_table("div_min_m1", OpDiv, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33, 33);
    run_table("divu_max_1", OpDivu, 32'hFFFFFFFF, 32'h1, 32'h0, 32'hFFFFFFFF, 33, 33);
    run_table("divu_5_9",  OpDivu, 32'd5, 32'd9, 32'd5, 32'd0, 33, 33);
  endtask

  task automatic test_div_zero();
    run_table("divu_zero", OpDivu, 32'h1234, 32'h0, 32'h1234, 32'hFFFFFFFF, 1, 1);
    run_table("div_zero",  OpDiv,  32'hFFFFFFF0, 32'h0, 32'hFFFFFFF0, 32'hFFFFFFFF, 1, 1);
  endtask

  task automatic test_flush();
    int saw_done;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = OpMthi; bus.src_a = 32'hAAAA;
    @(negedge clk);
    n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL mthi_stall got %b want 0", bus.stall); end
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = OpNone;
    @(negedge clk);
    n_checks++; if (bus.hi !== 32'hAAAA) begin n_fail++; $display("FAIL mthi_hi got %h want 0000aaaa", bus.hi); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mthi_busy got %b want 0", bus.busy); end
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = OpDiv; bus.src_a = 32'd100; bus.src_b = 32'd3;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
    end
    bus.flush = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall got %b want 0", bus.stall); end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL flush_busy_c10 got %b want 1", bus.busy); end
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.start = 1'b0; bus.op = OpNone;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy_c11 got %b want 0", bus.busy); end
    saw_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done) saw_done++;
    end
    n_checks++; if (saw_done !== 0) begin n_fail++; $display("FAIL flush_no_done got %0d want 0", saw_done); end
    n_checks++; if (bus.hi !== 32'hAAAA) begin n_fail++; $display("FAIL flush_hi got %h want 0000aaaa", bus.hi); end
    run_table("mult_after_flush", OpMult, 32'd3, 32'd5, 32'd0, 32'd15, 4, 4);
  endtask

  task automatic test_start_flush();
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = OpMult; bus.src_a = 32'd9; bus.src_b = 32'd9; bus.flush = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL sf_stall got %b want 0", bus.stall); end
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = OpNone; bus.flush = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL sf_busy got %b want 0", bus.busy); end
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = OpMtlo; bus.src_a = 32'h5555; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = OpNone; bus.flush = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.lo !== 32'd15) begin n_fail++; $display("FAIL sf_mtlo_lo got %h want 0000000f", bus.lo); end
  endtask

  task automatic test_undefined();
    logic [3:0] ops[2];
    ops[0] = 4'hF;
`ifdef MULDIV_ACC_EN
    ops[1] = 4'hB;
`else
    ops[1] = OpMadd;
`endif
    foreach (ops[i]) begin
      @(posedge clk); #1;
      bus.start = 1'b1; bus.op = ops[i]; bus.src_a = 32'd2; bus.src_b = 32'd2;
      @(negedge clk);
      n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL undef%0d_stall got %b want 0", i, bus.stall); end
      @(posedge clk); #1;
      bus.start = 1'b0; bus.op = OpNone;
      @(negedge clk);
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL undef%0d_busy got %b want 0", i, bus.busy); end
      n_checks++; if (bus.lo !== 32'd15) begin n_fail++; $display("FAIL undef%0d_lo got %h want 0000000f", i, bus.lo); end
    end
  endtask

`ifdef MULDIV_ACC_EN
  task automatic load_hilo(input logic [31:0] h, input logic [31:0] l);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = OpMthi; bus.src_a = h;
    @(posedge clk); #1;
    bus.op = OpMtlo; bus.src_a = l;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = OpNone;
  endtask

  task automatic test_acc();
    load_hilo(32'h0, 32'hFFFFFFFF);
    run_table("maddu", OpMaddu, 32'd1, 32'd1, 32'h1, 32'h0, 5, 5);
    load_hilo(32'h0, 32'h0);
    run_table("msub", OpMsub, 32'd1, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 5);
    run_table("madd_neg", OpMadd, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFE, 5, 5);
  endtask
`endif

  task automatic test_reset_mid();
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = OpDiv; bus.src_a = 32'd1000; bus.src_b = 32'd7;
    repeat (5) begin
      @(posedge clk); #1;
    end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before got %b want 1", bus.busy); end
    rst = 1'b1; bus.start = 1'b0; bus.op = OpNone;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if ({bus.stall, bus.done, bus.busy} !== 3'b000) begin
      n_fail++; $display("FAIL rmid_ctrl got %b want 000", {bus.stall, bus.done, bus.busy});
    end
    n_checks++; if ({bus.hi, bus.lo} !== 64'h0) begin
      n_fail++; $display("FAIL rmid_hilo got %h want 0", {bus.hi, bus.lo});
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = OpNone;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.flush = 1'b0;
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_flush();
    test_start_flush();
    test_undefined();
`ifdef MULDIV_ACC_EN
    test_acc();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
